// File: rtl/segment7_scan_driver.sv
// ---------------------------------------------------------------------------
// segment7_scan_driver
//
// Time-multiplexed driver for a DIGITS-wide common-segment 7-segment display.
// A packed BCD word is captured into a staging register on `load` and copied
// into the display (shadow) register only at a frame boundary. This keeps a
// new value from replacing the old one part-way through a frame. Each digit
// slot lasts SCAN_DIV clocks. The first clock of every slot is dead time:
// all digits are off, which prevents ghosting between digits. Digits at or
// above KEEP_DIGITS are blanked when they and every higher digit are zero.
//
// Optional feature macro: SEG7_BLINK_EN
//   When defined, the `blink` port and a frame counter are present. The
//   blink phase toggles every BLINK_FRAMES frames. The display goes dark
//   while blink=1 and the phase is 1.
//
// Parameters
//   DIGITS        number of digits (>=2); digit 0 is the rightmost
//   SCAN_DIV      clocks per digit slot (>=2)
//   KEEP_DIGITS   lowest digits that are never blanked (1..DIGITS)
//   BLINK_FRAMES  frames per blink half-period (SEG7_BLINK_EN only)
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   bcd_in      packed BCD, digit k = bcd_in[4k+3:4k]
//   load        one-cycle strobe that captures bcd_in
//   blank_all   level, forces all segments off (scanning continues)
//   blink       level, blink request (SEG7_BLINK_EN only)
//   seg_out     segments {a,b,c,d,e,f,g}, bit 6 = a, active high, registered
//   dig_sel     one-hot digit enable, active high, registered
//   frame_done  one-cycle pulse after the digit index wraps, registered
// ---------------------------------------------------------------------------
module segment7_scan_driver #(
  parameter int DIGITS      = 3,
  parameter int SCAN_DIV    = 1000,
  parameter int KEEP_DIGITS = 1
`ifdef SEG7_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                load,
  input  logic                blank_all,
`ifdef SEG7_BLINK_EN
  input  logic                blink,
`endif
  output logic [6:0]          seg_out,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_stage;
  logic [4*DIGITS-1:0] r_shadow;
  logic                r_pend;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_dig;
  logic                r_fd;

  logic                w_tc;
  logic                w_wrap;
  logic                w_dark;
  logic [3:0]          w_digits [DIGITS];
  logic [DIGITS-1:0]   w_lz_blank;
  logic [6:0]          w_pat;

  // Digit value to segment pattern; every non-BCD code shows a dash.
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'h7E;
      4'd1:    f_seg = 7'h30;
      4'd2:    f_seg = 7'h6D;
      4'd3:    f_seg = 7'h79;
      4'd4:    f_seg = 7'h33;
      4'd5:    f_seg = 7'h5B;
      4'd6:    f_seg = 7'h5F;
      4'd7:    f_seg = 7'h70;
      4'd8:    f_seg = 7'h7F;
      4'd9:    f_seg = 7'h7B;
      default: f_seg = 7'h01;
    endcase
  endfunction

  assign w_tc   = (r_cnt == CNT_LAST);
  assign w_wrap = w_tc && (r_idx == IDX_LAST);

  // Slot counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Staging and shadow registers. A load that lands on the wrap edge goes
  // straight to the shadow, so it is not deferred by a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage  <= '0;
      r_shadow <= '0;
      r_pend   <= 1'b0;
    end else begin
      if (load) r_stage <= bcd_in;
      if (w_wrap) begin
        if (load)        r_shadow <= bcd_in;
        else if (r_pend) r_shadow <= r_stage;
        r_pend <= 1'b0;
      end else if (load) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Leading-zero blanking: walk down from the top digit. A digit stays
  // blankable only while every digit from the top down to it is zero.
  // A dash code (>9) counts as non-zero.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    w_lz_blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_digits[k]   = r_shadow[4*k +: 4];
      zero_run      = zero_run && (w_digits[k] == 4'd0);
      w_lz_blank[k] = zero_run && (k >= KEEP_DIGITS);
    end
  end

  always_comb begin
    w_pat = f_seg(w_digits[r_idx]);
    if (blank_all || w_dark || w_lz_blank[r_idx]) w_pat = 7'h00;
  end

`ifdef SEG7_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] r_fcnt;
  logic            r_phase;

  // The phase free-runs on frame wraps, whether or not blink is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      if (r_fcnt == FC_LAST) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt <= r_fcnt + FC_W'(1);
      end
    end
  end

  assign w_dark = blink && r_phase;
`else
  assign w_dark = 1'b0;
`endif

  // Output registers; cnt==0 is the dead-time clock of each slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= 7'h00;
      r_dig <= '0;
      r_fd  <= 1'b0;
    end else begin
      r_fd <= w_wrap;
      if (r_cnt == '0) begin
        r_seg <= 7'h00;
        r_dig <= '0;
      end else begin
        r_seg <= w_pat;
        r_dig <= DIGITS'(1) << r_idx;
      end
    end
  end

  assign seg_out    = r_seg;
  assign dig_sel    = r_dig;
  assign frame_done = r_fd;

endmodule

// File: doc/segment7_scan_driver.md
# segment7_scan_driver

Time-multiplexed driver for a `DIGITS`-wide common-segment 7-segment display. It snapshots a packed BCD word, applies generalised leading-zero blanking, and scans one digit per `SCAN_DIV` clocks with a dead-time gap to prevent ghosting. It sits between the timer/BCD counters and the display pins, replacing per-digit static decoders.

## Interface
- `DIGITS`, 3: number of digits; digit 0 is least significant (rightmost); ≥2.
- `SCAN_DIV`, 1000: clocks per digit slot; ≥2.
- `KEEP_DIGITS`, 1: lowest digits never blanked; 1..`DIGITS`.
- `BLINK_FRAMES`, 64: frames per blink half-period; only used with `SEG7_BLINK_EN`.
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `bcd_in` in 4*`DIGITS`: packed BCD; digit k is `bcd_in[4k+3:4k]`.
- `load` in 1: one-cycle strobe; captures `bcd_in`.
- `blank_all` in 1: level; forces all segments off.
- `blink` in 1: level; present only with `SEG7_BLINK_EN`.
- `seg_out` out 7: segments {a,b,c,d,e,f,g}, bit 6 = a, active high, registered.
- `dig_sel` out `DIGITS`: one-hot digit enable, active high, registered.
- `frame_done` out 1: one-cycle pulse when digit index wraps, registered.

## Operation
- Staging register `stage` (4*`DIGITS`): written from `bcd_in` on `load`.
- Display register `shadow`: copied from `stage` at each frame boundary (index wrap) if a load is pending; the pending flag is then cleared. This prevents tearing mid-frame.
- `load` coincident with frame boundary: `shadow` takes `bcd_in` directly; pending is cleared.
- Slot counter `cnt` counts 0..`SCAN_DIV`-1. At terminal count, `idx` advances; `DIGITS`-1 wraps to 0 and marks the frame boundary.
- Decode, per digit value:
  - 0→7E, 1→30, 2→6D, 3→79, 4→33, 5→5B, 6→5F, 7→70, 8→7F, 9→7B.
  - 10..15→01 (segment g only, dash). Never X.
- Leading-zero blanking: digit k ≥ `KEEP_DIGITS` is blanked (00) when it and every higher digit of `shadow` is 0. A dash digit (value >9) is non-zero for this test.
- `blank_all`=1: `seg_out`=00; scanning and `dig_sel` continue unchanged.

## Timing
- Reset values: `cnt`=0, `idx`=0, `stage`=0, `shadow`=0, pending=0, `seg_out`=00, `dig_sel`=0, `frame_done`=0, blink phase=0.
- Outputs are registered from current `cnt`/`idx`/`shadow`: 1-cycle latency.
- Dead time: `dig_sel`=0 and `seg_out`=00 while `cnt`=0. During `cnt`=1..`SCAN_DIV`-1, `dig_sel`=1<<`idx` and `seg_out`=pattern.
- Each digit is lit for `SCAN_DIV`-1 of `SCAN_DIV` clocks. Frame period is `DIGITS`*`SCAN_DIV` clocks.
- `frame_done` pulses in the cycle after the edge where `idx` wraps to 0.
- `load` takes effect on display no later than the first slot of the next frame.
- Reset asserted mid-frame: all state returns to reset values immediately. After release, scanning restarts at digit 0 with `cnt`=0.

## Configuration
- `SEG7_BLINK_EN` defined:
  - `blink` port and a frame counter exist.
  - The blink phase toggles every `BLINK_FRAMES` frames.
  - While `blink`=1 and phase=1, `seg_out`=00.
  - Blink phase free-runs regardless of `blink`.
- Not defined: no `blink` port and no frame counter; behaviour is otherwise identical.

## Test plan
- Reset, then `load` with `bcd_in`=0x105, DIGITS=3, SCAN_DIV=4 → over the next frames, digit0 shows 5B, digit1 shows 7E, digit2 shows 30. `dig_sel` is 000 in every `cnt`=0 slot.
- `load` 0x007 → digit0 shows 70; digit1 and digit2 show 00. `load` 0x000 → digit0 shows 7E; others 00.
- `load` asserted mid-frame with 0x123 → the remainder of that frame shows the old value; the next frame shows 0x123. `load` on the wrap edge → the value is visible in the first slot of the following frame.
- `bcd_in`=0x0A0 → digit1 shows 01, digit2 shows 00, digit0 shows 7E (digit0 is shown because it is below `KEEP_DIGITS`).
- `blank_all`=1 for one full frame → `seg_out`=00 throughout. `dig_sel` still rotates 001→010→100, and `frame_done` pulses once per 12 clocks.
- With `SEG7_BLINK_EN`, BLINK_FRAMES=2, `blink`=1 → display is lit for 2 frames, dark for 2 frames, repeating. Reset asserted mid-sequence → all outputs 0 immediately.
